// File: rtl/debounce_pkg.sv
// Purpose: shared defaults and counter-width helper for the multi-channel debouncer.
// Latency: n/a (constants and functions only).
// Backpressure: none.
// Contents: DEF_CHANNELS, DEF_STABLE_CYCLES, DEF_REPEAT_CYCLES, cnt_width().
package debounce_pkg;

  localparam int DEF_CHANNELS      = 4;
  localparam int DEF_STABLE_CYCLES = 8;
  localparam int DEF_REPEAT_CYCLES = 16;

  // Bits needed to hold the values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// Purpose: one debounced channel - 2-flop synchroniser, stability counter, level and edge pulses.
// Latency: a clean edge on in_i reaches out_o 2+STABLE_CYCLES rising edges later; pulses coincide with out_o.
// Backpressure: none; free-running, every output is registered.
// Ports: clk, rst (async, active-high), in_i raw level, out_o debounced level,
//        press_o / release_o one-cycle pulses on debounced rise / fall.
// Build option: DEBOUNCE_REPEAT_EN adds auto-repeat press pulses every REPEAT_CYCLES while out_o is high.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef DEBOUNCE_REPEAT_EN
  , parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o,
  output logic press_o,
  output logic release_o
);

  localparam int             CW      = cnt_width(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int             RW      = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0]  RPT_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    out_d     = out_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (sync2_q == out_q) begin
      // Any return to the current level restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      out_d     = sync2_q;
      cnt_d     = '0;
      press_d   = sync2_q;
      release_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

`ifdef DEBOUNCE_REPEAT_EN
    // Held at zero while the level is low, which also covers the edge of the
    // initial press, so the first repeat lands REPEAT_CYCLES after it.
    rpt_d = rpt_q;
    if (!out_q) begin
      rpt_d = '0;
    end else if (rpt_q == RPT_MAX) begin
      rpt_d = '0;
      // Suppressed when the level is dropping on this same edge.
      press_d = out_d;
    end else begin
      rpt_d = rpt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      out_q     <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      sync1_q   <= in_i;
      sync2_q   <= sync1_q;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef DEBOUNCE_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign out_o     = out_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/multi_debouncer.sv
// Purpose: CHANNELS independent button/switch debouncers sharing one clock and reset.
// Latency: 2+STABLE_CYCLES rising edges from a clean input edge to out_o / press_o / release_o.
// Backpressure: none; outputs are registered level and single-cycle pulses.
// Ports: clk, rst (async, active-high), in_i[CHANNELS] raw levels, out_o debounced levels,
//        press_o / release_o per-channel one-cycle pulses.
// Build option: DEBOUNCE_REPEAT_EN enables auto-repeat press pulses (REPEAT_CYCLES otherwise unused).
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_i,
  output logic [CHANNELS-1:0] out_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o
);

  if (CHANNELS < 1 || STABLE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_err
    $error("multi_debouncer: CHANNELS>=1, STABLE_CYCLES>=1, REPEAT_CYCLES>=2 required");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES)
`ifdef DEBOUNCE_REPEAT_EN
      , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .in_i      (in_i[g]),
      .out_o     (out_o[g]),
      .press_o   (press_o[g]),
      .release_o (release_o[g])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Purpose: directed self-checking bench for multi_debouncer (CHANNELS=4, STABLE_CYCLES=8, REPEAT_CYCLES=16).
// Latency: inputs change 1ns after a rising edge; outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_multi_debouncer;

  logic       clk;
  logic       rst;
  logic [3:0] in_i;
  logic [3:0] out_o;
  logic [3:0] press_o;
  logic [3:0] release_o;

  int checks   = 0;
  int failures = 0;

`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  multi_debouncer #(
    .CHANNELS      (4),
    .STABLE_CYCLES (8),
    .REPEAT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_i      (in_i),
    .out_o     (out_o),
    .press_o   (press_o),
    .release_o (release_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, land 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] sticky;
    int         np, nr;
    logic       out2_at10;
    logic       exp_p, exp_r, exp_o;

    rst  = 1'b1;
    in_i = 4'b0000;
    tick(3);
    check("rst_out",  32'(out_o),     32'h0);
    check("rst_prs",  32'(press_o),   32'h0);
    check("rst_rel",  32'(release_o), 32'h0);
    rst = 1'b0;
    tick(2);

    // Single channel rise: out at edge 10, press in the same cycle only.
    in_i = 4'b0001;
    tick(9);
    check("rise_e9_out", 32'(out_o),   32'h0);
    check("rise_e9_prs", 32'(press_o), 32'h0);
    tick(1);
    check("rise_e10_out", 32'(out_o),     32'h1);
    check("rise_e10_prs", 32'(press_o),   32'h1);
    check("rise_e10_rel", 32'(release_o), 32'h0);
    tick(1);
    check("rise_e11_prs", 32'(press_o), 32'h0);
    check("rise_e11_out", 32'(out_o),   32'h1);

    // Single channel fall.
    in_i = 4'b0000;
    tick(9);
    check("fall_e9_out", 32'(out_o), 32'h1);
    tick(1);
    check("fall_e10_out", 32'(out_o),     32'h0);
    check("fall_e10_rel", 32'(release_o), 32'h1);
    check("fall_e10_prs", 32'(press_o),   32'h0);
    tick(1);
    check("fall_e11_rel", 32'(release_o), 32'h0);

    // Bounce every 3 cycles never reaches the output.
    sticky = '0;
    for (int i = 0; i < 10; i++) begin
      in_i[1] = ~in_i[1];
      for (int k = 0; k < 3; k++) begin
        tick(1);
        sticky |= out_o | press_o | release_o;
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1);
      sticky |= out_o | press_o | release_o;
    end
    check("bounce_quiet", 32'(sticky), 32'h0);

    // 7 synchronised samples high: filtered out.
    sticky = '0;
    in_i[2] = 1'b1;
    tick(7);
    in_i[2] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      sticky |= out_o | press_o | release_o;
    end
    check("pulse7_quiet", 32'(sticky), 32'h0);

    // 8 samples high: accepted, one press then one release.
    np = 0; nr = 0; out2_at10 = 1'b0;
    in_i[2] = 1'b1;
    tick(8);
    in_i[2] = 1'b0;
    for (int e = 9; e <= 30; e++) begin
      tick(1);
      if (press_o[2])   np++;
      if (release_o[2]) nr++;
      if (e == 10) out2_at10 = out_o[2];
    end
    check("pulse8_out_e10", 32'(out2_at10), 32'h1);
    check("pulse8_npress",  32'(np),        32'd1);
    check("pulse8_nrel",    32'(nr),        32'd1);
    check("pulse8_end_out", 32'(out_o),     32'h0);

    // All four channels pressed and released together.
    in_i = 4'b1111;
    tick(9);
    check("all_e9_prs",  32'(press_o), 32'h0);
    tick(1);
    check("all_e10_prs", 32'(press_o), 32'hF);
    check("all_e10_out", 32'(out_o),   32'hF);
    tick(1);
    check("all_e11_prs", 32'(press_o), 32'h0);
    in_i = 4'b0000;
    tick(10);
    check("all_rel_e10", 32'(release_o), 32'hF);
    check("all_rel_prs", 32'(press_o),   32'h0);
    check("all_rel_out", 32'(out_o),     32'h0);
    tick(3);

    // Long hold on channel 3: input high through edge 100, out falls at edge 110.
    in_i = 4'b1000;
    for (int e = 1; e <= 112; e++) begin
      tick(1);
      exp_o = (e >= 10) && (e < 110);
      exp_p = (e == 10) || (REP && e > 10 && e < 110 && ((e - 10) % 16) == 0);
      exp_r = (e == 110);
      check($sformatf("hold_out_e%0d", e), 32'(out_o[3]),     32'(exp_o));
      check($sformatf("hold_prs_e%0d", e), 32'(press_o[3]),   32'(exp_p));
      check($sformatf("hold_rel_e%0d", e), 32'(release_o[3]), 32'(exp_r));
      if (e == 100) in_i = 4'b0000;
    end
    tick(2);

    // Asynchronous reset mid-count, then recovery with inputs held.
    in_i = 4'b0010;
    tick(12);
    check("pre_rst_out", 32'(out_o), 32'h2);
    in_i = 4'b0011;
    tick(7);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out", 32'(out_o),     32'h0);
    check("arst_prs", 32'(press_o),   32'h0);
    check("arst_rel", 32'(release_o), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(9);
    check("post_rst_e9_out", 32'(out_o), 32'h0);
    tick(1);
    check("post_rst_e10_out", 32'(out_o),   32'h3);
    check("post_rst_e10_prs", 32'(press_o), 32'h3);
    tick(1);
    check("post_rst_e11_prs", 32'(press_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
